instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mem_req  out  1  one-cycle read request strobe to instruction memory.
REQ-006 mem_addr  out  32  word-aligned fetch address; valid while mem_req=1.
REQ-007 mem_ack  in  1  memory response strobe; mem_rdata valid in the same cycle.
REQ-008 mem_rdata  in  32  fetched instruction word.
REQ-009 redirect_valid  in  1  branch/jump redirect strobe.
REQ-010 redirect_pc  in  32  redirect target; bits [1:0] SHALL be forced to 0.
REQ-011 out_valid  out  1  decoded instruction available to decode stage.
REQ-012 out_ready  in  1  decode stage accepts; transfer when out_valid and out_ready are both 1.
REQ-013 out_pc  out  32  address of the presented instruction.
REQ-014 out_instr  out  32  raw instruction word.
REQ-015 out_opcode  out  7  instr[31:25].
REQ-016 out_rd  out  5  instr[24:20].
REQ-017 out_rs  out  5  instr[19:15].
REQ-018 out_imm  out  15  instr[14:0]; drives the sign extender input unchanged.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE -> REQ unconditionally on the first cycle after reset deasserts.
REQ-021 REQ: mem_req=1, mem_addr=pc for exactly one cycle; next state WAIT.
REQ-022 WAIT: hold until mem_ack; on mem_ack capture mem_rdata and pc into output registers, go HOLD; a mem_ack in any other state SHALL be ignored.
REQ-023 HOLD: out_valid=1; on out_ready, pc <= pc+4 and go REQ; otherwise all out_* SHALL remain stable.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 All out_* SHALL be registered; field outputs SHALL be slices of out_instr captured in the same edge.
REQ-026 Redirect in HOLD: out_valid deasserts the next cycle, pc <= redirect_pc, go REQ; if out_ready is also 1, the transfer counts and pc takes redirect_pc, not pc+4.
REQ-027 Redirect in REQ or WAIT: pc <= redirect_pc and a squash flag sets; the next mem_ack (including one coincident with the redirect) SHALL be discarded, then go REQ.
REQ-028 Redirect in IDLE: pc <= redirect_pc; sequencing unchanged.
REQ-029 Minimum issue interval SHALL be 3 cycles per instruction (REQ, WAIT with ack, HOLD with out_ready).

Reset
REQ-030 On rst=1: state=IDLE, pc=RESET_PC, squash=0, mem_req=0, mem_addr=0, out_valid=0, all other out_*=0.
REQ-031 rst mid-WAIT SHALL drop the outstanding request; a later mem_ack SHALL be ignored until the FSM re-enters WAIT.

Structure
REQ-032 Shared package cpu_pkg SHALL hold fetch_state_t, instruction field widths and bit positions (OPCODE 7, REG 5, IMM 15) and the PC increment constant 4.
REQ-033 One sub-module, pc_reg (PC register with load/increment/reset), SHALL be instantiated; the FSM and output registers remain in instr_fetch.

Verification
REQ-034 Reset release, mem_ack one cycle after mem_req with mem_rdata=32'h0862_00AB -> mem_addr=0, out_valid=1, out_opcode=7'd4, out_rd=5'd6, out_rs=5'd4, out_imm=15'h00AB, out_pc=0.
REQ-035 HOLD with out_ready=0 for 5 cycles, then 1 -> outputs constant for 5 cycles; next mem_req has mem_addr=32'h4.
REQ-036 redirect_valid=1, redirect_pc=32'h0000_0103 during WAIT, mem_ack the same cycle -> word discarded, out_valid stays 0, next mem_addr=32'h0000_0100.
REQ-037 RESET_PC=32'hFFFF_FFFC, one transfer accepted -> second mem_addr=32'h0000_0000.
REQ-038 redirect and out_ready both 1 in HOLD with redirect_pc=32'h40 -> one transfer, next mem_addr=32'h40.
REQ-039 rst asserted in WAIT, mem_ack arriving 1 cycle after rst deasserts -> ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction field
// geometry and PC stepping constants.
package cpu_pkg;

    localparam int XLEN = 32;

    // Instruction field widths
    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 15;

    // Instruction field least-significant bit positions
    localparam int OPCODE_LSB = 25;
    localparam int RD_LSB     = 20;
    localparam int RS_LSB     = 15;
    localparam int IMM_LSB    = 0;

    // PC stepping and word alignment
    localparam logic [XLEN-1:0] PC_INC         = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK  = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, word-aligned load
// (priority) or modulo-2^32 increment. Exposes the next value so the fetch
// FSM can register the outgoing request address in the same edge.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_val,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_next
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Next-PC selection: a redirect load wins over a sequential step
    always_comb begin
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = i_load_val & ~PC_ALIGN_MASK;
        end else if (i_inc) begin
            w_pc_next = r_pc + PC_INC;
        end
    end

    // PC state update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one-cycle memory read requests, waits for
// the response, and presents the instruction with decoded fields to decode.
// A redirect while a request is in flight squashes the next response.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [XLEN-1:0]     mem_addr,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_instr,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_rd,
    output logic [REG_W-1:0]    out_rs,
    output logic [IMM_W-1:0]    out_imm
);

    fetch_state_t          r_state;
    logic                  r_squash;
    logic                  r_mem_req;
    logic [XLEN-1:0]       r_mem_addr;
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_out_pc;
    logic [XLEN-1:0]       r_out_instr;
    logic [OPCODE_W-1:0]   r_out_opcode;
    logic [REG_W-1:0]      r_out_rd;
    logic [REG_W-1:0]      r_out_rs;
    logic [IMM_W-1:0]      r_out_imm;

    logic [XLEN-1:0]       w_pc;
    logic [XLEN-1:0]       w_pc_next;
    logic                  w_pc_inc;

    // Sequential step only on a plain accepted transfer; a redirect overrides it
    assign w_pc_inc = (r_state == HOLD) && out_ready && !redirect_valid;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (redirect_valid),
        .i_load_val (redirect_pc),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_next  (w_pc_next)
    );

    // Fetch FSM with registered memory-side and decode-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_squash     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_instr  <= '0;
            r_out_opcode <= '0;
            r_out_rd     <= '0;
            r_out_rs     <= '0;
            r_out_imm    <= '0;
        end else begin
            r_mem_req <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state    <= REQ;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_pc_next;
                end
                REQ: begin
                    r_state <= WAIT;
                    if (redirect_valid) begin
                        r_squash <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ack && (redirect_valid || r_squash)) begin
                        // Response belongs to a stale path: drop it and refetch
                        r_squash   <= 1'b0;
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_next;
                    end else if (redirect_valid) begin
                        r_squash <= 1'b1;
                    end else if (mem_ack) begin
                        r_state      <= HOLD;
                        r_out_valid  <= 1'b1;
                        r_out_pc     <= w_pc;
                        r_out_instr  <= mem_rdata;
                        r_out_opcode <= mem_rdata[OPCODE_LSB +: OPCODE_W];
                        r_out_rd     <= mem_rdata[RD_LSB +: REG_W];
                        r_out_rs     <= mem_rdata[RS_LSB +: REG_W];
                        r_out_imm    <= mem_rdata[IMM_LSB +: IMM_W];
                    end
                end
                HOLD: begin
                    if (redirect_valid || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_pc_next;
                    end
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_instr  = r_out_instr;
    assign out_opcode = r_out_opcode;
    assign out_rd     = r_out_rd;
    assign out_rs     = r_out_rs;
    assign out_imm    = r_out_imm;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Two instances share all inputs: one with the
// default reset PC, one starting at the top of the address space.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        a_mem_req,   b_mem_req;
    logic [31:0] a_mem_addr,  b_mem_addr;
    logic        a_out_valid, b_out_valid;
    logic [31:0] a_out_pc,    b_out_pc;
    logic [31:0] a_out_instr, b_out_instr;
    logic [6:0]  a_out_opcode, b_out_opcode;
    logic [4:0]  a_out_rd,    b_out_rd;
    logic [4:0]  a_out_rs,    b_out_rs;
    logic [14:0] a_out_imm,   b_out_imm;

    int n_tests;
    int n_fail;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut_a (
        .clk(clk), .rst(rst),
        .mem_req(a_mem_req), .mem_addr(a_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_instr(a_out_instr),
        .out_opcode(a_out_opcode), .out_rd(a_out_rd),
        .out_rs(a_out_rs), .out_imm(a_out_imm)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk(clk), .rst(rst),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr),
        .out_opcode(b_out_opcode), .out_rd(b_out_rd),
        .out_rs(b_out_rs), .out_imm(b_out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ack        = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check("rst_mem_req",   {31'b0, a_mem_req},   32'h0);
        check("rst_mem_addr",  a_mem_addr,           32'h0);
        check("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("rst_out_pc",    a_out_pc,             32'h0);
        check("rst_out_instr", a_out_instr,          32'h0);
        check("rst_b_mem_addr", b_mem_addr,          32'h0);

        // First fetch after reset release
        rst = 1'b0;
        tick();
        check("f0_mem_req",  {31'b0, a_mem_req}, 32'h1);
        check("f0_mem_addr", a_mem_addr,         32'h0);
        check("f0_b_mem_addr", b_mem_addr,       32'hFFFF_FFFC);
        tick();
        check("f0_req_oneshot", {31'b0, a_mem_req}, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0862_00AB;
        tick();
        mem_ack = 1'b0;
        check("f0_out_valid",  {31'b0, a_out_valid},  32'h1);
        check("f0_out_opcode", {25'b0, a_out_opcode}, 32'd4);
        check("f0_out_rd",     {27'b0, a_out_rd},     32'd6);
        check("f0_out_rs",     {27'b0, a_out_rs},     32'd4);
        check("f0_out_imm",    {17'b0, a_out_imm},    32'h00AB);
        check("f0_out_pc",     a_out_pc,              32'h0);
        check("f0_out_instr",  a_out_instr,           32'h0862_00AB);
        check("f0_b_out_pc",   b_out_pc,              32'hFFFF_FFFC);

        // Stall in HOLD for 5 cycles; a stray ack with new data must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'b0, a_out_valid}, 32'h1);
            check("hold_instr", a_out_instr,          32'h0862_00AB);
            check("hold_pc",    a_out_pc,             32'h0);
            check("hold_imm",   {17'b0, a_out_imm},   32'h00AB);
            check("hold_noreq", {31'b0, a_mem_req},   32'h0);
        end
        mem_ack   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("seq_mem_req",   {31'b0, a_mem_req},   32'h1);
        check("seq_mem_addr",  a_mem_addr,           32'h4);
        check("seq_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("wrap_b_mem_addr", b_mem_addr,         32'h0);

        // Redirect in WAIT with a coincident ack: word discarded, refetch aligned target
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        mem_ack        = 1'b1;
        mem_rdata      = 32'h1111_1111;
        tick();
        idle_inputs();
        check("sqw_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("sqw_mem_req",   {31'b0, a_mem_req},   32'h1);
        check("sqw_mem_addr",  a_mem_addr,           32'h0000_0100);
        check("sqw_out_instr", a_out_instr,          32'h0862_00AB);

        // Normal fetch at the redirected address
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_1234;
        tick();
        mem_ack = 1'b0;
        check("rd_out_valid", {31'b0, a_out_valid}, 32'h1);
        check("rd_out_pc",    a_out_pc,             32'h0000_0100);
        check("rd_out_instr", a_out_instr,          32'h0000_1234);

        // Redirect together with out_ready in HOLD: target wins over pc+4
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        out_ready      = 1'b1;
        tick();
        idle_inputs();
        check("rh_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("rh_mem_req",   {31'b0, a_mem_req},   32'h1);
        check("rh_mem_addr",  a_mem_addr,           32'h0000_0040);

        // Redirect in REQ: the next ack (arriving later in WAIT) is squashed
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        tick();
        idle_inputs();
        tick();
        check("sqr_still_wait", {31'b0, a_mem_req}, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        mem_ack = 1'b0;
        check("sqr_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("sqr_mem_req",   {31'b0, a_mem_req},   32'h1);
        check("sqr_mem_addr",  a_mem_addr,           32'h0000_0080);

        // Reset during WAIT; an ack one cycle after release is ignored
        tick();
        rst = 1'b1;
        tick();
        check("rw_mem_req",   {31'b0, a_mem_req},   32'h0);
        check("rw_mem_addr",  a_mem_addr,           32'h0);
        check("rw_out_valid", {31'b0, a_out_valid}, 32'h0);
        rst = 1'b0;
        tick();
        check("rw_restart_req",  {31'b0, a_mem_req}, 32'h1);
        check("rw_restart_addr", a_mem_addr,          32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_3333;
        tick();
        mem_ack = 1'b0;
        check("rw_stale_ack_valid", {31'b0, a_out_valid}, 32'h0);
        check("rw_stale_ack_instr", a_out_instr,          32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0862_00AB;
        tick();
        mem_ack = 1'b0;
        check("rw_fetch_valid", {31'b0, a_out_valid}, 32'h1);
        check("rw_fetch_pc",    a_out_pc,             32'h0);
        check("rw_fetch_instr", a_out_instr,          32'h0862_00AB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
